// File: rtl/ssd_scan_mux_if.sv
// Bus between the display scanner and its client: double-buffered digit
// data and strobe in, scan outputs for the segment decoder and anodes out.
interface ssd_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int SW = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    load;
  logic [3:0]              dig;
  logic [NUM_DIGITS-1:0]   anode;
  logic [SW-1:0]           digit_sel;
  logic                    frame_start;
  logic                    pending;

  modport master (
    output value, blank, load,
    input  dig, anode, digit_sel, frame_start, pending
  );

  modport slave (
    input  value, blank, load,
    output dig, anode, digit_sel, frame_start, pending
  );
endinterface

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed scanner for a common-anode seven-segment display.
// Staged digit data is committed only at the frame boundary so a frame
// never shows a mix of old and new values.
module ssd_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2,
  parameter bit ANODE_ACT    = 1'b0
) (
  input logic          clk,
  input logic          reset,
  ssd_scan_mux_if.slave bus
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = $clog2(NUM_DIGITS);
  localparam logic [SW-1:0] LAST_SEL = SW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE = PW'(REFRESH_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{~ANODE_ACT}};

  logic [PW-1:0]           presc;
  logic [SW-1:0]           sel;
  logic [4*NUM_DIGITS-1:0] stg_value, act_value;
  logic [NUM_DIGITS-1:0]   stg_blank, act_blank;
  logic                    pending_q;
  logic [3:0]              dig_q;
  logic [NUM_DIGITS-1:0]   anode_q;
  logic                    frame_q;

  logic                    tick, wrap, commit, dark, lit;
  logic [PW-1:0]           presc_nxt;
  logic [SW-1:0]           sel_nxt;
  logic [4*NUM_DIGITS-1:0] actv_nxt;
  logic [NUM_DIGITS-1:0]   actb_nxt;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   onehot;

  // Next scan position and active data; outputs are registered from these
  // so they change on the same edge as the counters themselves.
  always_comb begin
    tick      = (presc == LAST_PRE);
    wrap      = tick && (sel == LAST_SEL);
    commit    = wrap && pending_q;
    presc_nxt = tick ? '0 : presc + 1'b1;
    sel_nxt   = sel;
    if (tick) sel_nxt = (sel == LAST_SEL) ? '0 : sel + 1'b1;
    actv_nxt  = commit ? stg_value : act_value;
    actb_nxt  = commit ? stg_blank : act_blank;
    nib       = '0;
    dark      = 1'b1;
    onehot    = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (sel_nxt == SW'(k)) begin
        nib       = actv_nxt[4*k +: 4];
        dark      = actb_nxt[k];
        onehot[k] = 1'b1;
      end
    end
    lit = !dark && (int'({1'b0, presc_nxt}) >= BLANK_CYCLES);
  end

  // Prescaler, slot index, staging/active buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      sel       <= '0;
      stg_value <= '0;
      act_value <= '0;
      stg_blank <= '1;
      act_blank <= '1;
      pending_q <= 1'b0;
      dig_q     <= '0;
      anode_q   <= ANODE_OFF;
      frame_q   <= 1'b0;
    end else begin
      presc     <= presc_nxt;
      sel       <= sel_nxt;
      act_value <= actv_nxt;
      act_blank <= actb_nxt;
      // A load on the commit edge refills staging after the old contents
      // moved to active, so pending stays set for the following frame.
      if (bus.load) begin
        stg_value <= bus.value;
        stg_blank <= bus.blank;
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end
      dig_q   <= dark ? 4'h0 : nib;
      anode_q <= lit ? (ANODE_ACT ? onehot : ~onehot) : ANODE_OFF;
      frame_q <= wrap;
    end
  end

  assign bus.dig         = dig_q;
  assign bus.anode       = anode_q;
  assign bus.digit_sel   = sel;
  assign bus.frame_start = frame_q;
  assign bus.pending     = pending_q;
endmodule
